// File: rtl/bcd_entry_pkg.sv
// Shared types and constants for the two-digit BCD button entry block.
package bcd_entry_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_INC,
        CMD_DEC,
        CMD_CLR
    } cmd_t;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_RUN
    } rpt_state_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stability-count debouncer for one raw push button.
// Emits the debounced level and a one-cycle pulse on each debounced 0->1 transition.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    // The counter tracks how long sync has disagreed with level; any agreement restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            meta  <= btn;
            sync  <= meta;
            press <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync;
                press <= sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_button_entry.sv
// Two-digit BCD value entry from increment/decrement/clear buttons.
// Hold-to-repeat is compiled in only when BCD_BUTTON_ENTRY_REPEAT_EN is defined.
module bcd_button_entry
    import bcd_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_RATE     = 2500000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Inc_Btn,
    input  logic       i_Dec_Btn,
    input  logic       i_Clr_Btn,
    output bcd_digit_t o_Tens,
    output bcd_digit_t o_Ones,
    output logic       o_Changed,
    output logic       o_Wrap
);

    logic inc_lvl, dec_lvl, clr_lvl;
    logic inc_prs, dec_prs, clr_prs;
    logic inc_edge, dec_edge, clr_edge;
    logic rpt_step;
    logic rpt_dec;
    cmd_t cmd;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(i_Clk), .rst_n(i_Rst_L), .btn(i_Inc_Btn), .level(inc_lvl), .press(inc_prs)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clk(i_Clk), .rst_n(i_Rst_L), .btn(i_Dec_Btn), .level(dec_lvl), .press(dec_prs)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk(i_Clk), .rst_n(i_Rst_L), .btn(i_Clr_Btn), .level(clr_lvl), .press(clr_prs)
    );

    // A press pulse always coincides with its level being high; qualifying is harmless.
    assign inc_edge = inc_prs & inc_lvl;
    assign dec_edge = dec_prs & dec_lvl;
    assign clr_edge = clr_prs & clr_lvl;

`ifdef BCD_BUTTON_ENTRY_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

    rpt_state_t       rpt_state;
    logic [RPT_W-1:0] rpt_timer;
    logic             rpt_abort;

    assign rpt_abort = rpt_dec ? (!dec_lvl || inc_lvl || clr_lvl)
                               : (!inc_lvl || dec_lvl || clr_lvl);
    assign rpt_step  = (rpt_state != RPT_IDLE) && !rpt_abort && (rpt_timer == '0);

    // A fresh single-direction press always restarts the delay, even mid-repeat.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rpt_state <= RPT_IDLE;
            rpt_timer <= '0;
            rpt_dec   <= 1'b0;
        end else if (!clr_edge && (inc_edge ^ dec_edge)) begin
            rpt_state <= RPT_DELAY;
            rpt_timer <= RPT_W'(REPEAT_DELAY - 1);
            rpt_dec   <= dec_edge;
        end else if (clr_edge || rpt_abort) begin
            rpt_state <= RPT_IDLE;
            rpt_timer <= '0;
        end else if (rpt_state != RPT_IDLE) begin
            if (rpt_timer == '0) begin
                rpt_state <= RPT_RUN;
                rpt_timer <= RPT_W'(REPEAT_RATE - 1);
            end else begin
                rpt_timer <= rpt_timer - 1'b1;
            end
        end
    end
`else
    assign rpt_step = 1'b0;
    assign rpt_dec  = 1'b0;
`endif

    always_comb begin
        cmd = CMD_NONE;
        if (clr_edge)
            cmd = CMD_CLR;
        else if (inc_edge && !dec_edge)
            cmd = CMD_INC;
        else if (dec_edge && !inc_edge)
            cmd = CMD_DEC;
        else if (!inc_edge && !dec_edge && rpt_step)
            cmd = rpt_dec ? CMD_DEC : CMD_INC;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Tens    <= '0;
            o_Ones    <= '0;
            o_Changed <= 1'b0;
            o_Wrap    <= 1'b0;
        end else begin
            o_Changed <= (cmd != CMD_NONE);
            o_Wrap    <= 1'b0;
            case (cmd)
                CMD_INC: begin
                    if (o_Ones == BCD_MAX) begin
                        o_Ones <= '0;
                        if (o_Tens == BCD_MAX) begin
                            o_Tens <= '0;
                            o_Wrap <= 1'b1;
                        end else begin
                            o_Tens <= o_Tens + 4'd1;
                        end
                    end else begin
                        o_Ones <= o_Ones + 4'd1;
                    end
                end
                CMD_DEC: begin
                    if (o_Ones == '0) begin
                        o_Ones <= BCD_MAX;
                        if (o_Tens == '0) begin
                            o_Tens <= BCD_MAX;
                            o_Wrap <= 1'b1;
                        end else begin
                            o_Tens <= o_Tens - 4'd1;
                        end
                    end else begin
                        o_Ones <= o_Ones - 4'd1;
                    end
                end
                CMD_CLR: begin
                    o_Tens <= '0;
                    o_Ones <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
